// File: rtl/hyperram_traffic_gen.sv
// Self-checking HyperRAM traffic source: writes an LFSR pattern, reads it back in one burst, and counts mismatches.
// Optional watchdog enabled by defining HYPERRAM_TGEN_TIMEOUT_EN.
module hyperram_traffic_gen #(
   parameter int unsigned NUM_DWORDS = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] SEED       = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_count,
   output logic [31:0] first_err_addr,
   output logic        wr_req,
   output logic        rd_req,
   output logic        mem_or_reg,
   output logic [3:0]  wr_byte_en,
   output logic [21:0] rd_num_dwords,
   output logic [31:0] addr,
   output logic [31:0] wr_d,
   input  logic [31:0] rd_d,
   input  logic        rd_rdy,
   input  logic        busy
);

   localparam int unsigned    IDX_W     = 22;
   localparam logic [31:0]    LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0]    SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [IDX_W-1:0] NUM_W    = IDX_W'(NUM_DWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DWORDS - 1);

   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE} state_t;

   state_t             state;
   logic [31:0]        lfsr;
   logic [IDX_W-1:0]   idx;
   logic               wait_first;
   logic               err_hit_c;
   logic [31:0]        err_addr_c;
   logic [15:0]        err_count_nxt_c;
   logic               wdog_fire_c;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'd0);
   endfunction

   assign mem_or_reg = 1'b0;
   assign wr_byte_en = 4'hF;

   // A read strobe is an error if it mismatches, or arrives when no read data is expected.
   always_comb begin
      err_hit_c  = 1'b0;
      err_addr_c = BASE_ADDR + 32'(NUM_DWORDS);
      if (rd_rdy) begin
         if (state == RD_WAIT && idx != NUM_W) begin
            err_hit_c  = (rd_d != lfsr);
            err_addr_c = BASE_ADDR + 32'(idx);
         end else begin
            err_hit_c  = 1'b1;
         end
      end
      err_count_nxt_c = (err_hit_c && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
   end

`ifdef HYPERRAM_TGEN_TIMEOUT_EN
   logic [11:0] wdog;
   state_t      wd_state;

   assign wdog_fire_c = (state inside {WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT}) &&
                        state == wd_state && !rd_rdy && wdog == 12'hFFF;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog     <= 12'd0;
         wd_state <= IDLE;
         timeout  <= 1'b0;
      end else begin
         wd_state <= state;
         if (!(state inside {WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT}) || state != wd_state || rd_rdy)
            wdog <= 12'd0;
         else
            wdog <= wdog + 12'd1;
         if (wdog_fire_c)
            timeout <= 1'b1;
         else if (start && (state == IDLE || state == DONE))
            timeout <= 1'b0;
      end
   end
`else
   assign wdog_fire_c = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         lfsr           <= 32'd0;
         idx            <= '0;
         wait_first     <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 16'd0;
         first_err_addr <= 32'd0;
         wr_req         <= 1'b0;
         rd_req         <= 1'b0;
         rd_num_dwords  <= '0;
         addr           <= 32'd0;
         wr_d           <= 32'd0;
      end else begin
         wr_req        <= 1'b0;
         rd_req        <= 1'b0;
         rd_num_dwords <= '0;
         if (err_hit_c) begin
            err_count <= err_count_nxt_c;
            if (err_count == 16'd0)
               first_err_addr <= err_addr_c;
         end
         case (state)
            IDLE, DONE: begin
               if (state == DONE && err_hit_c)
                  pass <= 1'b0;
               if (start) begin
                  err_count      <= 16'd0;
                  first_err_addr <= 32'd0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  lfsr           <= SEED_EFF;
                  idx            <= '0;
                  state          <= WR_ISSUE;
               end
            end
            WR_ISSUE: begin
               if (!busy) begin
                  wr_req     <= 1'b1;
                  addr       <= BASE_ADDR + 32'(idx);
                  wr_d       <= lfsr;
                  wait_first <= 1'b1;
                  state      <= WR_WAIT;
               end
            end
            // busy may not have risen yet in the first wait cycle
            WR_WAIT: begin
               wait_first <= 1'b0;
               if (!wait_first && !busy) begin
                  if (idx == LAST_IDX) begin
                     lfsr  <= SEED_EFF;
                     idx   <= '0;
                     state <= RD_ISSUE;
                  end else begin
                     lfsr  <= lfsr_step(lfsr);
                     idx   <= idx + 22'd1;
                     state <= WR_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               if (!busy) begin
                  rd_req        <= 1'b1;
                  addr          <= BASE_ADDR;
                  rd_num_dwords <= NUM_W;
                  state         <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (rd_rdy && idx != NUM_W) begin
                  lfsr <= lfsr_step(lfsr);
                  idx  <= idx + 22'd1;
               end
               if (idx == NUM_W && !busy) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= (err_count_nxt_c == 16'd0);
               end
            end
            default: state <= IDLE;
         endcase
         if (wdog_fire_c) begin
            state         <= DONE;
            done          <= 1'b1;
            pass          <= 1'b0;
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            rd_num_dwords <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hyperram_traffic_gen.sv
// Bench for hyperram_traffic_gen: randomized controller/memory model, two instances (base 0 and wrapping base).
module tb_hyperram_traffic_gen;

   localparam int unsigned N      = 4;
   localparam logic [31:0] BASE_A = 32'h0000_0000;
   localparam logic [31:0] BASE_B = 32'hFFFF_FFFE;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        busy = 1'b0;
   logic        rd_rdy = 1'b0;
   logic [31:0] rd_d = 32'd0;

   logic        a_done, a_pass, a_timeout, a_wr_req, a_rd_req, a_mem_or_reg;
   logic [15:0] a_err_count;
   logic [31:0] a_first_err_addr, a_addr, a_wr_d;
   logic [3:0]  a_wr_byte_en;
   logic [21:0] a_rd_num_dwords;
   logic        b_done, b_pass, b_timeout, b_wr_req, b_rd_req, b_mem_or_reg;
   logic [15:0] b_err_count;
   logic [31:0] b_first_err_addr, b_addr, b_wr_d;
   logic [3:0]  b_wr_byte_en;
   logic [21:0] b_rd_num_dwords;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hyperram_traffic_gen #(.NUM_DWORDS(N), .BASE_ADDR(BASE_A), .SEED(32'h1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .done(a_done), .pass(a_pass),
      .timeout(a_timeout), .err_count(a_err_count), .first_err_addr(a_first_err_addr),
      .wr_req(a_wr_req), .rd_req(a_rd_req), .mem_or_reg(a_mem_or_reg),
      .wr_byte_en(a_wr_byte_en), .rd_num_dwords(a_rd_num_dwords), .addr(a_addr),
      .wr_d(a_wr_d), .rd_d(rd_d), .rd_rdy(rd_rdy), .busy(busy));

   hyperram_traffic_gen #(.NUM_DWORDS(N), .BASE_ADDR(BASE_B), .SEED(32'h0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .done(b_done), .pass(b_pass),
      .timeout(b_timeout), .err_count(b_err_count), .first_err_addr(b_first_err_addr),
      .wr_req(b_wr_req), .rd_req(b_rd_req), .mem_or_reg(b_mem_or_reg),
      .wr_byte_en(b_wr_byte_en), .rd_num_dwords(b_rd_num_dwords), .addr(b_addr),
      .wr_d(b_wr_d), .rd_d(rd_d), .rd_rdy(rd_rdy), .busy(busy));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference pattern: i-th Galois LFSR state from the seed.
   function automatic logic [31:0] pattern(input logic [31:0] seed, input int i);
      logic [31:0] x = (seed == 32'd0) ? 32'd1 : seed;
      for (int k = 0; k < i; k++)
         x = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'd0);
      return x;
   endfunction

   function automatic logic sig(input int w);
      case (w)
         0:       return a_wr_req;
         1:       return a_rd_req;
         default: return a_done;
      endcase
   endfunction

   task automatic wait_sig(input int w, input int budget, input string tag);
      int n = 0;
      while (!sig(w) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(sig(w)), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_flags"}, {26'd0, a_wr_req, a_rd_req, a_done, a_pass, a_timeout, a_mem_or_reg}, 32'd0);
      check({tag, "_addr"}, a_addr, 32'd0);
      check({tag, "_wr_d"}, a_wr_d, 32'd0);
      check({tag, "_errs"}, {a_err_count, 16'd0} | 32'(a_rd_num_dwords), 32'd0);
      check({tag, "_first"}, a_first_err_addr, 32'd0);
      check({tag, "_b_addr"}, b_addr, 32'd0);
   endtask

   // One full run against a modelled controller; optional corruption, extra strobes, busy-at-start, mid-read reset.
   task automatic run(input int cidx, input int cbit, input int extra, input bit prebusy, input int rst_after);
      logic [31:0] mem [N];
      logic [31:0] flip;
      int          exp_err = 0;
      logic [31:0] exp_first_a = 32'd0;
      logic [31:0] exp_first_b = 32'd0;
      int          seen;
      @(negedge clk);
      if (prebusy) busy = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (prebusy) begin
         seen = 0;
         repeat (20) begin
            @(negedge clk);
            if (a_wr_req) seen++;
         end
         check("busy_hold_no_wr", 32'(seen), 32'd0);
         busy = 1'b0;
         @(negedge clk);
         check("wr_after_busy_fall", 32'(a_wr_req), 32'd1);
      end
      for (int i = 0; i < int'(N); i++) begin
         wait_sig(0, 200, "wr_req_seen");
         check("wr_addr", a_addr, BASE_A + 32'(i));
         check("wr_data", a_wr_d, pattern(32'h1, i));
         check("wr_addr_wrap", b_addr, BASE_B + 32'(i));
         mem[i] = a_wr_d;
         busy = 1'b1;
         @(negedge clk);
         check("wr_pulse_width", 32'(a_wr_req), 32'd0);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         busy = 1'b0;
      end
      wait_sig(1, 200, "rd_req_seen");
      check("rd_num", 32'(a_rd_num_dwords), N);
      check("rd_addr", a_addr, BASE_A);
      check("rd_addr_wrap", b_addr, BASE_B);
      busy = 1'b1;
      for (int k = 0; k < int'(N) + extra; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         flip = (k == cidx) ? (32'd1 << cbit) : 32'd0;
         rd_d = (k < int'(N)) ? (mem[k] ^ flip) : $urandom;
         rd_rdy = 1'b1;
         @(negedge clk);
         rd_rdy = 1'b0;
         if (k >= int'(N) || k == cidx) begin
            if (exp_err == 0) begin
               exp_first_a = BASE_A + 32'(k);
               exp_first_b = BASE_B + 32'(k);
            end
            exp_err++;
         end
         check("err_count_latency", 32'(a_err_count), 32'(exp_err));
         if (rst_after == k + 1) begin
            #2 reset = 1'b1;
            #1 check_reset_outs("async_reset");
            busy = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      busy = 1'b0;
      wait_sig(2, 200, "done_seen");
      check("pass", 32'(a_pass), 32'(exp_err == 0));
      check("err_count", 32'(a_err_count), 32'(exp_err));
      check("first_err_addr", a_first_err_addr, exp_first_a);
      check("timeout", 32'(a_timeout), 32'd0);
      check("b_done_pass", {30'd0, b_done, b_pass}, {30'd0, 1'b1, 1'(exp_err == 0)});
      check("b_first_err_addr", b_first_err_addr, exp_first_b);
   endtask

   initial begin
      #1 reset = 1'b1;
      #3;
      check_reset_outs("reset");
      check("byte_en", 32'(a_wr_byte_en), 32'hF);
      @(negedge clk);
      reset = 1'b0;

      run(-1, 0, 0, 1'b0, 0);          // clean pattern
      run(2, 0, 0, 1'b0, 0);           // bit 0 of dword 2 flipped
      run(-1, 0, 0, 1'b1, 0);          // busy high when start arrives
      run(-1, 0, 1, 1'b0, 0);          // one strobe too many
      for (int r = 0; r < 4; r++)
         run(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, N - 1)) : -1,
             int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), 1'b0, 0);
      run(-1, 0, 0, 1'b0, 2);          // reset during read-back
      run(-1, 0, 0, 1'b0, 0);

`ifdef HYPERRAM_TGEN_TIMEOUT_EN
      begin
         int n = 0;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_sig(0, 200, "wd_wr_req");
         busy = 1'b1;
         while (!a_done && n < 5000) begin
            @(negedge clk);
            n++;
         end
         check("wd_done", 32'(a_done), 32'd1);
         check("wd_timeout", 32'(a_timeout), 32'd1);
         check("wd_pass", 32'(a_pass), 32'd0);
         busy = 1'b0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
